// File: rtl/fsm_walk_tracker_pkg.sv
// Shared types and helpers for the state-walk tracker.
package fsm_walk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_e;

  // Saturating increment of a counter of the given width (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/fsm_walk_tracker_next.sv
// Next-state law of the walked vector: gated bit 0, free-running increment above it.
module fsm_walk_next #(
  parameter int SW = 2
) (
  input  logic [SW-1:0] state,
  input  logic          a,
  output logic [SW-1:0] next_state
);

  assign next_state[0]      = ~(a & state[0]);
  assign next_state[SW-1:1] = state[SW-1:1] + (SW-1)'(1);

endmodule

// File: rtl/fsm_walk_tracker.sv
// Walks a state vector from a loaded start point, counting target hits and RUN cycles.
module fsm_walk_tracker
  import fsm_walk_pkg::*;
#(
  parameter int             SW          = 2,
  parameter logic [SW-1:0]  TARGET      = SW'(2),
  parameter int             CW          = 16,
  parameter int             MAX_CYCLES  = 0,
  parameter bit             STOP_ON_HIT = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [SW-1:0] init_state,
  input  logic          a,
  output logic [SW-1:0] state,
  output logic [SW-1:0] next_state,
  output logic          hit,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] first_hit_cycle,
  output logic          first_hit_valid,
  output logic          running,
  output logic          done
);

  ctrl_e ctrl, ctrl_nxt;
  logic  load, upd, adv, budget_end;

  fsm_walk_next #(.SW(SW)) u_next (
    .state      (state),
    .a          (a),
    .next_state (next_state)
  );

  assign running    = (ctrl == RUN);
  assign done       = (ctrl == DONE);
  assign hit        = running && (state == TARGET);
  assign budget_end = (MAX_CYCLES != 0) && (cycle_count == CW'(MAX_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ctrl <= IDLE;
    else          ctrl <= ctrl_nxt;
  end

  // load: restart; upd: count this RUN cycle's hit; adv: step state and cycle index.
  always_comb begin
    ctrl_nxt = ctrl;
    load     = 1'b0;
    upd      = 1'b0;
    adv      = 1'b0;
    case (ctrl)
      IDLE, DONE: begin
        if (start) begin
          load     = 1'b1;
          ctrl_nxt = RUN;
        end
      end
      RUN: begin
        if (start) begin
          load = 1'b1;
        end else begin
          upd = 1'b1;
          if (STOP_ON_HIT && hit) ctrl_nxt = DONE;
          else if (budget_end)    ctrl_nxt = DONE;
          else                    adv = 1'b1;
        end
      end
      default: ctrl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= '0;
      hit_count       <= '0;
      cycle_count     <= '0;
      first_hit_cycle <= '0;
      first_hit_valid <= 1'b0;
    end else if (load) begin
      state           <= init_state;
      hit_count       <= '0;
      cycle_count     <= '0;
      first_hit_cycle <= '0;
      first_hit_valid <= 1'b0;
    end else if (upd) begin
      if (hit) begin
        hit_count <= CW'(sat_inc(32'(hit_count), CW));
        if (!first_hit_valid) begin
          first_hit_cycle <= cycle_count;
          first_hit_valid <= 1'b1;
        end
      end
      // On the stopping edge state and cycle index stay put.
      if (adv) begin
        state       <= next_state;
        cycle_count <= CW'(sat_inc(32'(cycle_count), CW));
      end
    end
  end

endmodule

// File: tb/tb_fsm_walk_tracker.sv
// Scoreboard bench: four tracker variants (default, budget 8, stop-on-hit, 3-bit counters).
module tb_fsm_walk_tracker;

  logic clock = 1'b0;
  logic reset_n;
  logic [3:0]       start, a;
  logic [3:0][1:0]  init, st, ns;
  logic [3:0]       hitv, fhv, run, dn;
  logic [3:0][15:0] hc, cc, fhc;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int CWG = (g == 3) ? 3 : 16;
    localparam int MXG = (g == 1) ? 8 : 0;
    localparam bit SOH = (g == 2);
    logic [CWG-1:0] hc_w, cc_w, fh_w;
    fsm_walk_tracker #(
      .SW(2), .TARGET(2'b10), .CW(CWG), .MAX_CYCLES(MXG), .STOP_ON_HIT(SOH)
    ) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start[g]),
      .init_state      (init[g]),
      .a               (a[g]),
      .state           (st[g]),
      .next_state      (ns[g]),
      .hit             (hitv[g]),
      .hit_count       (hc_w),
      .cycle_count     (cc_w),
      .first_hit_cycle (fh_w),
      .first_hit_valid (fhv[g]),
      .running         (run[g]),
      .done            (dn[g])
    );
    assign hc[g]  = 16'(hc_w);
    assign cc[g]  = 16'(cc_w);
    assign fhc[g] = 16'(fh_w);
  end

  typedef struct {
    int          cyc;
    int          d;
    string       name;
    logic [1:0]  st, ns;
    logic        hit;
    logic [15:0] hc, cc, fhc;
    logic        fhv, run, dn;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int d, input logic [1:0] s, input logic [1:0] n,
                     input logic h, input int h_c, input int c_c, input int f_c,
                     input logic f_v, input logic r, input logic dd);
    exp_t e;
    e.cyc = cyc; e.d = d; e.name = name; e.st = s; e.ns = n; e.hit = h;
    e.hc = 16'(h_c); e.cc = 16'(c_c); e.fhc = 16'(f_c); e.fhv = f_v; e.run = r; e.dn = dd;
    q.push_back(e);
  endtask

  function automatic int min7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Monitor: compares every expectation due at or before this cycle's sampling point.
  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || st[e.d] !== e.st || ns[e.d] !== e.ns || hitv[e.d] !== e.hit ||
          hc[e.d] !== e.hc || cc[e.d] !== e.cc || fhc[e.d] !== e.fhc ||
          fhv[e.d] !== e.fhv || run[e.d] !== e.run || dn[e.d] !== e.dn) begin
        errors++;
        $display("FAIL %s dut%0d cyc%0d: got st=%b ns=%b hit=%b hc=%0d cc=%0d fhc=%0d fhv=%b run=%b done=%b; want st=%b ns=%b hit=%b hc=%0d cc=%0d fhc=%0d fhv=%b run=%b done=%b (due cyc%0d)",
                 e.name, e.d, cyc, st[e.d], ns[e.d], hitv[e.d], hc[e.d], cc[e.d], fhc[e.d],
                 fhv[e.d], run[e.d], dn[e.d], e.st, e.ns, e.hit, e.hc, e.cc, e.fhc,
                 e.fhv, e.run, e.dn, e.cyc);
      end
    end
  end

  initial begin
    logic [1:0] s, n;
    logic [1:0] w[5];
    logic [1:0] wn[5];
    int c0, k0;
    w  = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b01};
    wn = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11};

    reset_n = 1'b0; start = '0; a = '0; init = '0;
    repeat (2) step();
    for (int d = 0; d < 4; d++) chk("reset", d, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    step();
    for (int d = 0; d < 4; d++) chk("idle", d, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0);

    // All four variants start together from 01 with a=1.
    for (int d = 0; d < 4; d++) begin start[d] = 1'b1; init[d] = 2'b01; a[d] = 1'b1; end
    for (int d = 0; d < 4; d++) chk("idle_start", d, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    step();
    start = '0;
    c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      s = k[0] ? 2'b10 : 2'b01;
      n = k[0] ? 2'b01 : 2'b10;
      chk("walk", 0, s, n, k[0], k / 2, k, (k >= 2) ? 1 : 0, k >= 2, 1, 0);
      if (k <= 7) chk("budget", 1, s, n, k[0], k / 2, k, (k >= 2) ? 1 : 0, k >= 2, 1, 0);
      else        chk("budget_done", 1, 2'b10, 2'b01, 0, 4, 7, 1, 1, 0, 1);
      if (k <= 1) chk("stop", 2, s, n, k[0], 0, k, 0, 0, 1, 0);
      else        chk("stop_done", 2, 2'b10, 2'b01, 0, 1, 1, 1, 1, 0, 1);
      chk("sat", 3, s, n, k[0], min7(k / 2), min7(k), (k >= 2) ? 1 : 0, k >= 2, 1, 0);
      step();
    end

    // Restart the budget variant from DONE with init equal to the target, a=0.
    start[1] = 1'b1; init[1] = 2'b10; a[1] = 1'b0;
    chk("done_hold", 1, 2'b10, 2'b01, 0, 4, 7, 1, 1, 0, 1);
    step();
    start[1] = 1'b0;
    chk("init_tgt_k0", 1, 2'b10, 2'b01, 1, 0, 0, 0, 0, 1, 0);
    step();
    chk("init_tgt_k1", 1, 2'b01, 2'b11, 0, 1, 1, 0, 1, 1, 0);
    start[1] = 1'b1; init[1] = 2'b00;
    step();
    start[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("a0_walk", 1, w[k], wn[k], 0, 0, k, 0, 0, 1, 0);
      step();
    end

    // Restart the default variant in a hit cycle: that hit must not be counted.
    k0 = cyc - c0;
    if (!k0[0]) begin step(); k0 = cyc - c0; end
    start[0] = 1'b1; init[0] = 2'b10; a[0] = 1'b1;
    chk("restart_hit", 0, 2'b10, 2'b01, 1, k0 / 2, k0, 1, 1, 1, 0);
    step();
    start[0] = 1'b0;
    chk("restart_k0", 0, 2'b10, 2'b01, 1, 0, 0, 0, 0, 1, 0);
    step();
    chk("restart_k1", 0, 2'b01, 2'b10, 0, 1, 1, 0, 1, 1, 0);
    step();

    // Asynchronous reset mid-RUN, sampled before any further clock edge.
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) chk("reset_mid", d, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    for (int d = 0; d < 4; d++) chk("post_reset", d, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
